// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, clock-enable gated bit timing.
// Define UART_RX_PARITY_EN to add an even-parity bit between bit 7 and the stop bit (8E1).
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;
`endif

  state_t        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic          pbit_q, pbit_d;
  logic          parity_err_q, parity_err_d;
`endif

  // Synchronizer runs every clk so ce gating never widens the metastability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      pbit_q       <= pbit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Pulses default low every clk (not just ce cycles) so they last exactly one clk.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_d       = pbit_q;
    parity_err_d = 1'b0;
`endif
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d          = '0;
            shift_d[idx_q] = rxs_q;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            pbit_d  = rxs_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (!rxs_q) begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_HIGH;
            end else begin
              state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if ((^shift_q) ^ pbit_q) begin
                parity_err_d = 1'b1;
              end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end
`else
              data_d  = shift_q;
              valid_d = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: latency, glitch, framing, back-to-back,
// mid-frame reset, ce throttling and (with UART_RX_PARITY_EN) parity.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // rx drive -> 2 sync flops -> IDLE detect edge, then half bit plus the remaining bit times.
  localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst, ce, rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int checks = 0, errors = 0;
  int cyc = 0, fall_cyc = 0, last_valid_cyc = 0;
  int nvalid = 0, nferr = 0, nperr = 0, noverlap = 0;
  int v0, f0, p0, lat;
  logic ce_tog = 1'b0;
  logic [7:0] hist [0:15];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .ce(ce), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      hist[nvalid % 16] = data;
      nvalid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) nferr++;
    if (parity_err) nperr++;
    if ((int'(valid) + int'(frame_err) + int'(parity_err)) > 1) noverlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ce = ce_tog ? ~ce : 1'b1;
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, input logic pbit, input int n);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (n) tick();
    for (int i = 0; i < 8; i++) hold(b[i], n);
`ifdef UART_RX_PARITY_EN
    hold(pbit, n);
`endif
    hold(stopb, n);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; rx = 1'b1;
    #12;
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick(); tick();
    rst = 1'b0;
    hold(1'b1, 5);

    // Plain 0x55 with latency check
    v0 = nvalid;
    send_frame(8'h55, 1'b1, ^8'h55, CPB);
    hold(1'b1, 20);
    check("b55_count", nvalid - v0, 1);
    check("b55_data", data, 8'h55);
    check("b55_lat", last_valid_cyc - fall_cyc, LAT);
    check("b55_busy", busy, 1'b0);

    // Short low glitch must be rejected in START
    v0 = nvalid; f0 = nferr; p0 = nperr;
    hold(1'b0, 4);
    check("glitch_busy_hi", busy, 1'b1);
    hold(1'b1, 20);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_pulses", (nvalid - v0) + (nferr - f0) + (nperr - p0), 0);

    // Bad stop bit followed by a break
    v0 = nvalid; f0 = nferr;
    send_frame(8'hA3, 1'b0, ^8'hA3, CPB);
    hold(1'b0, 40);
    check("ferr_count", nferr - f0, 1);
    check("ferr_novalid", nvalid - v0, 0);
    check("ferr_data_hold", data, 8'h55);
    check("ferr_busy_wait", busy, 1'b1);
    hold(1'b1, 20);
    check("ferr_busy_lo", busy, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C, CPB);
    hold(1'b1, 20);
    check("after_ferr_count", nvalid - v0, 1);
    check("after_ferr_data", data, 8'h3C);
    check("after_ferr_ferr", nferr - f0, 1);

    // Back-to-back frames, zero idle gap
    v0 = nvalid;
    send_frame(8'h00, 1'b1, ^8'h00, CPB);
    send_frame(8'hFF, 1'b1, ^8'hFF, CPB);
    hold(1'b1, 20);
    check("b2b_count", nvalid - v0, 2);
    check("b2b_first", hist[v0 % 16], 8'h00);
    check("b2b_second", hist[(v0 + 1) % 16], 8'hFF);

    // Reset in the middle of data bit 4
    v0 = nvalid; f0 = nferr; p0 = nperr;
    hold(1'b0, CPB);
    hold(1'b1, CPB); hold(1'b0, CPB); hold(1'b1, CPB); hold(1'b0, CPB);
    hold(1'b1, CPB / 2);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 20);
    check("mid_rst_pulses", (nvalid - v0) + (nferr - f0) + (nperr - p0), 0);
    send_frame(8'h81, 1'b1, ^8'h81, CPB);
    hold(1'b1, 20);
    check("post_rst_count", nvalid - v0, 1);
    check("post_rst_data", data, 8'h81);

    // ce at half rate: bit time doubles in clk
    v0 = nvalid; f0 = nferr;
    ce_tog = 1'b1;
    send_frame(8'h81, 1'b1, ^8'h81, 2 * CPB);
    hold(1'b1, 40);
    ce_tog = 1'b0;
    lat = last_valid_cyc - fall_cyc;
    check("ce_count", nvalid - v0, 1);
    check("ce_data", hist[v0 % 16], 8'h81);
    check("ce_lat_window", (lat >= 2 * (LAT - 3) + 1) && (lat <= 2 * (LAT - 3) + 6), 1'b1);
    check("ce_ferr", nferr - f0, 0);

`ifdef UART_RX_PARITY_EN
    v0 = nvalid; p0 = nperr;
    hold(1'b1, 10);
    send_frame(8'h01, 1'b1, 1'b0, CPB);
    hold(1'b1, 20);
    check("par_bad_perr", nperr - p0, 1);
    check("par_bad_novalid", nvalid - v0, 0);
    check("par_bad_data", data, 8'h81);
    send_frame(8'h01, 1'b1, 1'b1, CPB);
    hold(1'b1, 20);
    check("par_good_valid", nvalid - v0, 1);
    check("par_good_data", data, 8'h01);
    check("par_good_perr", nperr - p0, 1);
`else
    check("no_parity_pulses", nperr, 0);
`endif
    check("no_overlap", noverlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
